// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr_select.sv
// ============================================================================
// Module      : mem_arb_rr_select
// Description : Combinational round-robin grant picker with lock override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr_select
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_last_grant,
    input  logic                 i_locked,
    output logic                 o_valid,
    output logic                 o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = 1'b0;
        if (i_locked) begin
            // Locked: only the previous owner may be considered.
            o_valid = i_req[i_last_grant];
            o_idx   = i_last_grant;
        end else if (&i_req) begin
            o_idx = ~i_last_grant;
        end else if (i_req[1]) begin
            o_idx = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-port memory arbiter with watchdog bus fault.
//               Optional atomic lock support with MEM_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS-1:0][1:0]   size,
    input  logic [NUM_PORTS-1:0][31:0]  addr,
    input  logic [NUM_PORTS-1:0][31:0]  wdata,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic [NUM_PORTS-1:0]        lock,
`endif
    output logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS-1:0]        fault,
    output logic [31:0]                 rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [1:0]                  mem_size,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_ack,
    input  logic                        mem_fault,
    output logic                        gnt_id
);

    localparam logic [TIMEOUT_W-1:0] c_WDOG_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;
    logic                   r_gnt;
    logic                   r_we;
    logic [1:0]             r_size;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_pend_fault;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic                   w_gnt_valid;
    logic                   w_gnt_idx;
    logic                   w_locked;
    logic                   w_timeout;

`ifdef MEM_ARBITER_LOCK_EN
    logic                   r_locked;

    // Lock persists only while the owner keeps both req and lock asserted.
    assign w_locked = r_locked & req[r_last_grant] & lock[r_last_grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (r_state == RESP) begin
            r_locked <= lock[r_gnt];
        end else if (r_state == IDLE) begin
            r_locked <= 1'b0;
        end
    end
`else
    assign w_locked = 1'b0;
`endif

    mem_arb_rr_select u_rr_select (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .i_locked     (w_locked),
        .o_valid      (w_gnt_valid),
        .o_idx        (w_gnt_idx)
    );

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog == c_WDOG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ack          = '0;
        fault        = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
                ack[r_gnt]   = 1'b1;
                fault[r_gnt] = r_pend_fault;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_pend_fault <= 1'b0;
            r_wdog       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt        <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_we         <= we[w_gnt_idx];
                        r_size       <= size[w_gnt_idx];
                        r_addr       <= addr[w_gnt_idx];
                        r_wdata      <= wdata[w_gnt_idx];
                        r_wdog       <= '0;
                    end
                end
                ISSUE: begin
                    // A real ack beats a coincident watchdog expiry.
                    if (mem_ack) begin
                        r_rdata      <= mem_rdata;
                        r_pend_fault <= mem_fault;
                    end else if (w_timeout) begin
                        r_rdata      <= '0;
                        r_pend_fault <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (r_state == ISSUE);
    assign mem_we    = r_we;
    assign mem_size  = r_size;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign gnt_id    = r_gnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter (lock test under
//               MEM_ARBITER_LOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lk;
    } txn_t;

    typedef struct {
        logic        gnt;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dur;
    } iss_t;

    typedef struct {
        int          wait_cyc;
        logic [31:0] rdata;
        logic        flt;
    } plan_t;

    typedef struct {
        logic        port;
        logic        flt;
        logic [31:0] rdata;
        logic        via_ack;
    } rsp_t;

    logic              clk;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0][1:0]   size;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic [1:0]        lock;
`endif
    logic [1:0]        ack;
    logic [1:0]        fault;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              mem_fault;
    logic              gnt_id;

    txn_t  q0[$];
    txn_t  q1[$];
    iss_t  exp_iss[$];
    plan_t plans[$];
    rsp_t  exp_rsp[$];

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   issue_cyc;
    int   spurious_req;
    logic mem_ack_q;

    mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_W      (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
`ifdef MEM_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .fault     (fault),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_fault (mem_fault),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_ack_q <= mem_ack;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Queue one transaction plus the issue, memory and response it should produce.
    task automatic expect_txn(input logic p, input logic w, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, input logic lk,
                              input int wt, input logic [31:0] mrd, input logic mf);
        txn_t  t;
        iss_t  i;
        plan_t pl;
        rsp_t  r;
        bit    to;
        to = (wt < 0) || (wt >= TO);
        t.we = w; t.size = sz; t.addr = a; t.wdata = wd; t.lk = lk;
        if (p == 1'b0) q0.push_back(t); else q1.push_back(t);
        i.gnt = p; i.we = w; i.size = sz; i.addr = a; i.wdata = wd;
        i.dur = to ? TO : wt + 1;
        exp_iss.push_back(i);
        pl.wait_cyc = wt; pl.rdata = mrd; pl.flt = mf;
        plans.push_back(pl);
        r.port = p; r.flt = to ? 1'b1 : mf; r.rdata = to ? 32'h0 : mrd; r.via_ack = !to;
        exp_rsp.push_back(r);
    endtask

    // Requester model: each port holds req until its ack, reloads at the RESP edge.
    task automatic run_ports(input int budget);
        logic [1:0] busy;
        logic [1:0] done;
        txn_t       t;
        int         n;
        busy = 2'b00;
        n    = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy != 2'b00) && n < budget) begin
            for (int p = 0; p < 2; p++) begin
                if (!busy[p] && ((p == 0) ? q0.size() : q1.size()) > 0) begin
                    if (p == 0) t = q0.pop_front(); else t = q1.pop_front();
                    req[p]   = 1'b1;
                    we[p]    = t.we;
                    size[p]  = t.size;
                    addr[p]  = t.addr;
                    wdata[p] = t.wdata;
`ifdef MEM_ARBITER_LOCK_EN
                    lock[p]  = t.lk;
`endif
                    busy[p]  = 1'b1;
                end
            end
            @(negedge clk);
            done = busy & ack;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    busy[p] = 1'b0;
                    req[p]  = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
                    lock[p] = 1'b0;
`endif
                end
            end
            n++;
        end
        if (busy != 2'b00 || q0.size() > 0 || q1.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_ports_timeout: actual busy=%b required all acked", busy);
            q0.delete();
            q1.delete();
        end
        req = 2'b00;
`ifdef MEM_ARBITER_LOCK_EN
        lock = 2'b00;
`endif
    endtask

    initial begin : mem_model
        plan_t pl;
        bit    active;
        int    cnt;
        int    sp_done;
        mem_ack = 1'b0; mem_rdata = 32'h0; mem_fault = 1'b0;
        active = 1'b0; cnt = -1; sp_done = 0;
        pl.wait_cyc = 0; pl.rdata = 32'h0; pl.flt = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_fault = 1'b0;
            if (!mem_req) begin
                active = 1'b0;
                if (spurious_req != sp_done) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hFFFF_FFFF;
                    mem_fault = 1'b1;
                    sp_done   = spurious_req;
                end
            end else begin
                if (!active) begin
                    active = 1'b1;
                    if (plans.size() > 0) pl = plans.pop_front();
                    else begin pl.wait_cyc = 0; pl.rdata = 32'h0; pl.flt = 1'b0; end
                    cnt = pl.wait_cyc;
                end
                if (cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = pl.rdata;
                    mem_fault = pl.flt;
                    cnt       = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
            end
        end
    end

    initial begin : issue_mon
        iss_t e;
        logic prev;
        int   d;
        bit   have;
        prev = 1'b0; d = 0; have = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev) begin
                issue_cyc = cyc;
                d = 1;
                if (exp_iss.size() == 0) begin
                    n_checks++; n_fail++; have = 1'b0;
                    $display("FAIL unexpected_issue: actual addr=0x%0h required none", mem_addr);
                end else begin
                    e = exp_iss.pop_front();
                    have = 1'b1;
                    chk("issue_gnt_id", gnt_id, e.gnt);
                    chk("issue_we", mem_we, e.we);
                    chk("issue_size", mem_size, e.size);
                    chk("issue_addr", mem_addr, e.addr);
                    chk("issue_wdata", mem_wdata, e.wdata);
                end
            end else if (mem_req) begin
                d++;
                if (have) chk("issue_hold", {mem_we, mem_size, mem_addr, mem_wdata},
                              {e.we, e.size, e.addr, e.wdata});
            end else if (prev && have) begin
                if (e.dur >= 0) chk("issue_cycles", d, e.dur);
                have = 1'b0;
            end
            prev = mem_req;
        end
    end

    initial begin : resp_mon
        rsp_t       r;
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            if (ack != 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: actual ack=%b required none", ack);
                end else begin
                    r  = exp_rsp.pop_front();
                    oh = 2'b01 << r.port;
                    chk("ack_vector", ack, oh);
                    chk("fault_vector", fault, r.flt ? oh : 2'b00);
                    chk("rdata", rdata, r.rdata);
                    chk("ack_after_mem_ack", mem_ack_q, r.via_ack);
                end
            end else if (fault != 2'b00) begin
                n_checks++; n_fail++;
                $display("FAIL fault_without_ack: actual fault=%b required 00", fault);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: actual time=%0t required finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int start_cyc;
        int n;
        reset = 1'b1; req = 2'b00; we = 2'b00; size = '0; addr = '0; wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
        lock = 2'b00;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_side", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, '0);
        chk("reset_port_side", {ack, fault, rdata, gnt_id}, '0);
        reset = 1'b0;

        // Single read, two memory wait states.
        expect_txn(1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 1'b0, 2, 32'hDEADBEEF, 1'b0);
        start_cyc = cyc;
        run_ports(50);
        chk("req_to_mem_req_latency", issue_cyc - start_cyc, 1);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, 32'hDEADBEEF);

        // Contention straight out of reset: strict alternation 0,1,0,1,0,1.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        expect_txn(1'b0, 1'b1, SIZE_BYTE, 32'h1000, 32'h0000_00A5, 1'b0, 0, 32'h1111_1111, 1'b0);
        expect_txn(1'b1, 1'b0, SIZE_HALF, 32'h2002, 32'h0,         1'b0, 1, 32'h2222_2222, 1'b0);
        expect_txn(1'b0, 1'b1, SIZE_HALF, 32'h1004, 32'h0000_BEEF, 1'b0, 0, 32'h3333_3333, 1'b0);
        expect_txn(1'b1, 1'b0, SIZE_WORD, 32'h2008, 32'h0,         1'b0, 2, 32'hBAD0_0001, 1'b1);
        expect_txn(1'b0, 1'b0, SIZE_WORD, 32'h100C, 32'h0,         1'b0, 0, 32'h5555_5555, 1'b0);
        expect_txn(1'b1, 1'b1, SIZE_WORD, 32'h2010, 32'h0102_0304, 1'b0, 0, 32'h6666_6666, 1'b0);
        run_ports(200);

        // Watchdog: memory never answers port 1's write.
        expect_txn(1'b1, 1'b1, SIZE_WORD, 32'h200, 32'hCAFE_F00D, 1'b0, -1, 32'h0, 1'b0);
        run_ports(60);

        // Ack lands on the last watchdog cycle and must win.
        expect_txn(1'b0, 1'b0, SIZE_WORD, 32'h300, 32'h0, 1'b0, TO - 1, 32'h1234_5678, 1'b0);
        run_ports(60);

        // Stray mem_ack while idle must be ignored.
        spurious_req = spurious_req + 1;
        repeat (4) @(negedge clk);
        chk("idle_ack_rdata_unchanged", rdata, 32'h1234_5678);
        chk("idle_ack_no_mem_req", mem_req, 1'b0);

        // Reset while an access is outstanding.
        begin
            iss_t  i;
            plan_t pl;
            i.gnt = 1'b0; i.we = 1'b0; i.size = SIZE_WORD; i.addr = 32'h400; i.wdata = 32'h0; i.dur = -1;
            exp_iss.push_back(i);
            pl.wait_cyc = -1; pl.rdata = 32'h0; pl.flt = 1'b0;
            plans.push_back(pl);
        end
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; size[0] = SIZE_WORD; addr[0] = 32'h400; wdata[0] = 32'h0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_mem_req_seen", mem_req, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_mem_side", {mem_req, mem_we, mem_size, mem_addr, mem_wdata}, '0);
        chk("async_reset_port_side", {ack, fault, rdata, gnt_id}, '0);
        req = 2'b00;
        @(posedge clk); #1 reset = 1'b0;
        expect_txn(1'b0, 1'b0, SIZE_WORD, 32'h404, 32'h0, 1'b0, 0, 32'h7777_7777, 1'b0);
        expect_txn(1'b1, 1'b0, SIZE_WORD, 32'h408, 32'h0, 1'b0, 0, 32'h8888_8888, 1'b0);
        run_ports(50);

`ifdef MEM_ARBITER_LOCK_EN
        // Port 0 holds lock over a read-modify-write while port 1 waits.
        expect_txn(1'b0, 1'b0, SIZE_WORD, 32'h500, 32'h0,         1'b1, 0, 32'hA0A0_A0A0, 1'b0);
        expect_txn(1'b0, 1'b1, SIZE_WORD, 32'h500, 32'hA0A0_A0A1, 1'b1, 0, 32'h0,         1'b0);
        expect_txn(1'b1, 1'b0, SIZE_WORD, 32'h600, 32'h0,         1'b0, 0, 32'h0B0B_0B0B, 1'b0);
        run_ports(60);
`endif

        repeat (5) @(negedge clk);
        chk("issue_queue_drained", exp_iss.size(), 0);
        chk("resp_queue_drained", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
